// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Sequences the ALU between the UART Rx and Tx FIFOs. Pops
//                operand A, operand B and an opcode byte, pulses the ALU
//                start, waits for completion under a timeout guard and pushes
//                the result byte (or an error byte on timeout) to the Tx FIFO.
//                Optional build macro ALU_SEQ_FLAGS_BYTE_EN adds a second Tx
//                byte carrying the ALU flags after each result.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    OPCODE_WIDTH   = 6,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERROR_BYTE     = 8'hEE
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rxfifo_empty,
    input  logic [DATA_WIDTH-1:0]   i_rxfifo_data,
    output logic                    o_rxfifo_read,
    input  logic                    i_txfifo_full,
    output logic                    o_txfifo_write,
    output logic [DATA_WIDTH-1:0]   o_txfifo_data,
    output logic [DATA_WIDTH-1:0]   o_operand_a,
    output logic [DATA_WIDTH-1:0]   o_operand_b,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic                    o_alu_start,
    input  logic                    i_alu_done,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic                    i_alu_zero,
    input  logic                    i_alu_carry,
    input  logic                    i_alu_overflow,
    input  logic                    i_alu_negative,
    input  logic                    i_alu_exception,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic [15:0]             o_op_count
);

    // State encoding
    localparam logic [2:0] c_ST_GET_A   = 3'd0;
    localparam logic [2:0] c_ST_GET_B   = 3'd1;
    localparam logic [2:0] c_ST_GET_OP  = 3'd2;
    localparam logic [2:0] c_ST_EXEC    = 3'd3;
    localparam logic [2:0] c_ST_WAIT    = 3'd4;
    localparam logic [2:0] c_ST_PUT_RES = 3'd5;
`ifdef ALU_SEQ_FLAGS_BYTE_EN
    localparam logic [2:0] c_ST_PUT_FLG = 3'd6;
`endif

    // Counter wide enough to hold TIMEOUT_CYCLES-1 even when TIMEOUT_CYCLES is 1
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]              r_state;
    logic [DATA_WIDTH-1:0]   r_operand_a;
    logic [DATA_WIDTH-1:0]   r_operand_b;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic                    r_alu_start;
    logic                    r_timeout;
    logic [15:0]             r_op_count;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    w_in_get;
    logic                    w_rx_pop;
    logic                    w_tx_push;

`ifdef ALU_SEQ_FLAGS_BYTE_EN
    // {exception, negative, overflow, carry, zero}
    logic [4:0]              r_flags;
`else
    // Flag inputs only matter when the flags byte is built in
    logic                    w_unused_flags;
    assign w_unused_flags = ^{i_alu_zero, i_alu_carry, i_alu_overflow,
                              i_alu_negative, i_alu_exception};
`endif

    assign w_in_get = (r_state == c_ST_GET_A) || (r_state == c_ST_GET_B) ||
                      (r_state == c_ST_GET_OP);
    assign w_rx_pop = w_in_get && !i_rxfifo_empty;

`ifdef ALU_SEQ_FLAGS_BYTE_EN
    assign w_tx_push = ((r_state == c_ST_PUT_RES) || (r_state == c_ST_PUT_FLG)) &&
                       !i_txfifo_full;
`else
    assign w_tx_push = (r_state == c_ST_PUT_RES) && !i_txfifo_full;
`endif

    assign o_rxfifo_read  = w_rx_pop;
    assign o_txfifo_write = w_tx_push;
    assign o_operand_a    = r_operand_a;
    assign o_operand_b    = r_operand_b;
    assign o_opcode       = r_opcode;
    assign o_alu_start    = r_alu_start;
    assign o_busy         = (r_state != c_ST_GET_A);
    assign o_timeout      = r_timeout;
    assign o_op_count     = r_op_count;

    // Tx byte selection: result in PUT_RES, flags in PUT_FLG, zero otherwise
    always_comb begin
        o_txfifo_data = '0;
        if (r_state == c_ST_PUT_RES) begin
            o_txfifo_data = r_result;
        end
`ifdef ALU_SEQ_FLAGS_BYTE_EN
        if (r_state == c_ST_PUT_FLG) begin
            o_txfifo_data = {{(DATA_WIDTH-5){1'b0}}, r_flags};
        end
`endif
    end

    // Main sequencer: byte collection, ALU handshake with timeout, Tx push
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= c_ST_GET_A;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_alu_start <= 1'b0;
            r_timeout   <= 1'b0;
            r_op_count  <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
`ifdef ALU_SEQ_FLAGS_BYTE_EN
            r_flags     <= '0;
`endif
        end else begin
            // Start is a single pulse aligned with the EXEC cycle
            r_alu_start <= 1'b0;
            case (r_state)
                c_ST_GET_A: begin
                    if (!i_rxfifo_empty) begin
                        r_operand_a <= i_rxfifo_data;
                        r_state     <= c_ST_GET_B;
                    end
                end
                c_ST_GET_B: begin
                    if (!i_rxfifo_empty) begin
                        r_operand_b <= i_rxfifo_data;
                        r_state     <= c_ST_GET_OP;
                    end
                end
                c_ST_GET_OP: begin
                    if (!i_rxfifo_empty) begin
                        r_opcode    <= i_rxfifo_data[OPCODE_WIDTH-1:0];
                        r_alu_start <= 1'b1;
                        r_state     <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                    r_state   <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // A done arriving in the last allowed cycle beats the timeout
                    if (i_alu_done) begin
                        r_result <= i_alu_result;
`ifdef ALU_SEQ_FLAGS_BYTE_EN
                        r_flags  <= {i_alu_exception, i_alu_negative,
                                     i_alu_overflow, i_alu_carry, i_alu_zero};
`endif
                        r_state  <= c_ST_PUT_RES;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_result  <= ERROR_BYTE;
`ifdef ALU_SEQ_FLAGS_BYTE_EN
                        r_flags   <= 5'b10000;
`endif
                        r_timeout <= 1'b1;
                        r_state   <= c_ST_PUT_RES;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_PUT_RES: begin
                    if (!i_txfifo_full) begin
`ifdef ALU_SEQ_FLAGS_BYTE_EN
                        r_state    <= c_ST_PUT_FLG;
`else
                        r_op_count <= r_op_count + 16'd1;
                        r_state    <= c_ST_GET_A;
`endif
                    end
                end
`ifdef ALU_SEQ_FLAGS_BYTE_EN
                c_ST_PUT_FLG: begin
                    if (!i_txfifo_full) begin
                        r_op_count <= r_op_count + 16'd1;
                        r_state    <= c_ST_GET_A;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_GET_A;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
